// File: rtl/serial_bit_feeder_if.sv
// Word-in / bit-out bundle between an upstream word source and the serial bit feeder.
// The master side presents words; the slave side (the feeder) drives the serial stream and frame status.
interface serial_bit_feeder_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
    logic             out;
    logic             bit_valid;
    logic             frame_done;
    logic             busy;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready,
        input  out,
        input  bit_valid,
        input  frame_done,
        input  busy
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready,
        output out,
        output bit_valid,
        output frame_done,
        output busy
    );
endinterface

// File: rtl/serial_bit_feeder.sv
// Serialises parallel words onto a single bit line, one bit every DIV clocks, for the sequence detector.
// Back-to-back words stream with no idle bit; frame_done pulses once after each completed word.
module serial_bit_feeder #(
    parameter int   WIDTH      = 8,
    parameter int   DIV        = 1,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input logic               clk,
    input logic               rst,
    serial_bit_feeder_if.slave bus
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = $clog2(WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] shift_reg;
    logic [BIT_W-1:0] bit_cnt;
    logic [DIV_W-1:0] div_cnt;

    logic             out_q;
    logic             bit_valid_q;
    logic             frame_done_q;
    logic             busy_q;

    logic             bit_end;
    logic             word_end;
    logic             ready;
    logic             accept;

    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] load_shift;
    logic [WIDTH-1:0] advance_shift;

    // shift_reg only ever holds the bits still to be sent, so the next bit is always at the leading end
    always_comb begin
        if (MSB_FIRST) begin
            first_bit     = bus.data_in[WIDTH-1];
            next_bit      = shift_reg[WIDTH-1];
            load_shift    = bus.data_in << 1;
            advance_shift = shift_reg << 1;
        end else begin
            first_bit     = bus.data_in[0];
            next_bit      = shift_reg[0];
            load_shift    = bus.data_in >> 1;
            advance_shift = shift_reg >> 1;
        end
    end

    // Ready opens in the final clock of the final bit so the next word follows without a gap
    always_comb begin
        bit_end    = 1'b0;
        word_end   = 1'b0;
        state_next = state;
        if (state == SHIFT) begin
            bit_end  = (div_cnt == DIV_LAST);
            word_end = bit_end && (bit_cnt == BIT_LAST);
        end
        ready  = !rst && ((state == IDLE) || word_end);
        accept = ready && bus.data_valid;
        case (state)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (word_end && !accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg    <= '0;
            bit_cnt      <= '0;
            div_cnt      <= '0;
            out_q        <= IDLE_LEVEL;
            bit_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            frame_done_q <= word_end;
            if (accept) begin
                shift_reg   <= load_shift;
                out_q       <= first_bit;
                bit_valid_q <= 1'b1;
                busy_q      <= 1'b1;
                bit_cnt     <= '0;
                div_cnt     <= '0;
            end else if (state == SHIFT) begin
                if (word_end) begin
                    out_q       <= IDLE_LEVEL;
                    bit_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    bit_cnt     <= '0;
                    div_cnt     <= '0;
                end else if (bit_end) begin
                    div_cnt   <= '0;
                    bit_cnt   <= bit_cnt + BIT_W'(1);
                    out_q     <= next_bit;
                    shift_reg <= advance_shift;
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end
        end
    end

    assign bus.data_ready = ready;
    assign bus.out        = out_q;
    assign bus.bit_valid  = bit_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;

endmodule

// File: doc/serial_bit_feeder.md
Name: serial_bit_feeder

Overview:
- Upstream stage of the serial sequence-detector Moore machine.
- Accepts a parallel word over a valid/ready handshake and emits it as a serial bit stream on `out`, one bit every DIV clocks; `out` drives the detector's `in` directly.
- Back-to-back words stream with no idle bit between them. Frame status is flagged for the bench/monitor.

Parameters:
- WIDTH, 8, bits per word; legal range >= 2.
- DIV, 1, clocks each bit is held on `out`; legal range >= 1.
- MSB_FIRST, 1, 1 = data_in[WIDTH-1] sent first; 0 = data_in[0] sent first.
- IDLE_LEVEL, 0, value driven on `out` when no word is in flight.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous reset, active-high.
- data_in  input  WIDTH  word to serialise; sampled only on an accept edge.
- data_valid  input  1  upstream has a word.
- data_ready  output  1  feeder can accept a word this cycle.
- out  output  1  serial bit to the sequence detector.
- bit_valid  output  1  `out` carries a data bit (not idle).
- frame_done  output  1  one-cycle pulse after the last bit of a word completes.
- busy  output  1  word in flight (state SHIFT).

Behaviour:
- Reset (asynchronous, active-high; one clock, no other clock domains):
  - Immediate on rst high: state = IDLE, out = IDLE_LEVEL, bit_valid = 0, frame_done = 0, busy = 0, counters = 0.
  - data_ready is forced 0 while rst is high.
- States:
  - IDLE: data_ready = 1. `out` is not in flight.
  - SHIFT: data_ready = 1 only in the last clock of the last bit (bit_cnt == WIDTH-1 and div_cnt == DIV-1); otherwise 0.
- Accept: rising edge with data_valid && data_ready. On the same edge:
  - shift register <= data_in.
  - out <= first bit per MSB_FIRST.
  - bit_valid <= 1, busy <= 1, bit_cnt <= 0, div_cnt <= 0, state <= SHIFT.
  - Latency: first data bit visible on `out` in the cycle after the accept edge.
- Bit timing in SHIFT:
  - div_cnt increments each clock. At div_cnt == DIV-1 it wraps to 0, bit_cnt increments, and `out` advances to the next bit.
  - Each bit is stable for exactly DIV clocks. A full word occupies WIDTH*DIV clocks.
- End of word, at the edge ending the last bit's final clock:
  - frame_done <= 1 for exactly one cycle.
  - If a new word is accepted on that same edge: load per Accept; `out` shows the new first bit in the next cycle with no gap; state stays SHIFT; bit_valid stays 1.
  - Otherwise: state <= IDLE, out <= IDLE_LEVEL, bit_valid <= 0, busy <= 0.
- data_valid asserted while data_ready = 0 is ignored. The word is not captured and the in-flight word is not disturbed. Upstream must hold data_valid/data_in until accepted.
- data_in changes mid-word have no effect; only the registered copy is shifted.
- Reset mid-word aborts the frame at once. No frame_done is issued, and the partial word is discarded.
- Counter widths: div_cnt = clog2(DIV) bits (minimum 1); bit_cnt = clog2(WIDTH) bits. No counter ever exceeds its terminal value.
- DIV = 1: div_cnt is effectively constant 0, and every clock advances one bit.
- All outputs except data_ready are registered. data_ready is combinational from state/counters/rst only, never from data_valid.

Test Plan:
1. WIDTH=8, DIV=1, MSB_FIRST=1. Release rst, present data_in=8'hB0 with data_valid=1 for one accept.
   - `out` = 1,0,1,1,0,0,0,0 on 8 consecutive cycles after the accept, with bit_valid=1 throughout.
   - frame_done pulses once in the 9th cycle; out returns to 0 and busy=0.
   - Downstream detector fed from `out` reaches S3 with Z=1 after the fourth bit.
2. Back-to-back: data_valid held high with 8'hB0, then 8'h5A.
   - Second accept coincides with the last bit of the first word; `out` = 10110000 01011010 with no idle cycle.
   - bit_valid never drops between words; frame_done pulses twice, 8 cycles apart.
3. DIV=3, data_in=8'hA5: each bit is held exactly 3 clocks, the frame lasts 24 clocks, and data_ready=0 for clocks 1-23 of the frame.
4. MSB_FIRST=0, data_in=8'h0D: `out` = 1,0,1,1,0,0,0,0 (LSB first).
5. Assert rst asynchronously (mid-cycle) during the 4th bit of 8'hFF.
   - out goes to IDLE_LEVEL immediately; bit_valid=0, busy=0, data_ready=0 while rst is high.
   - No frame_done; after release, a new 8'h81 serialises correctly from bit 0.
6. data_valid pulsed with 8'h00 while busy (mid-word of 8'hF0): the pulse is ignored, the in-flight stream 11110000 is unchanged, and exactly one frame_done is issued.
